// File: rtl/hier_bcast_collect_node.sv
// Hierarchy node: broadcasts one upstream request to NUM_CHILD children,
// sums their responses with NODE_ID and returns one upstream response.
module hier_bcast_collect_node #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W = 16,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] NODE_ID = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        up_req_valid,
  output logic                        up_req_ready,
  input  logic [DATA_W-1:0]           up_req_data,
  output logic [NUM_CHILD-1:0]        dn_req_valid,
  input  logic [NUM_CHILD-1:0]        dn_req_ready,
  output logic [DATA_W-1:0]           dn_req_data,
  input  logic [NUM_CHILD-1:0]        dn_rsp_valid,
  input  logic [NUM_CHILD*DATA_W-1:0] dn_rsp_data,
  output logic                        up_rsp_valid,
  input  logic                        up_rsp_ready,
  output logic [DATA_W-1:0]           up_rsp_data,
  output logic [NUM_CHILD-1:0]        up_rsp_mask,
  output logic                        up_rsp_timeout,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, COLLECT, RESPOND
  } state_t;

  localparam logic [NUM_CHILD-1:0] ALL = '1;
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t               state;
  logic [NUM_CHILD-1:0] issue_pend;
  logic [NUM_CHILD-1:0] rsp_mask;
  logic [DATA_W-1:0]    acc;
  logic [15:0]          cnt;

  logic                 active;
  logic [NUM_CHILD-1:0] take;
  logic [NUM_CHILD-1:0] mask_nxt;
  logic [DATA_W-1:0]    sum_nxt;
  logic [15:0]          cnt_nxt;
  logic                 done;
  logic                 timed_out;

  assign up_req_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign dn_req_valid = issue_pend;
  assign active       = (state == ISSUE) || (state == COLLECT);
  assign cnt_nxt      = cnt + 16'd1;
  assign done         = &mask_nxt;
  assign timed_out    = (cnt_nxt == TMO);

  // Only issued children that have not yet answered contribute
  always_comb begin
    take     = active ? (dn_rsp_valid & ~issue_pend & ~rsp_mask) : '0;
    mask_nxt = rsp_mask | take;
    sum_nxt  = acc;
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (take[i]) sum_nxt = sum_nxt + dn_rsp_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      issue_pend     <= '0;
      rsp_mask       <= '0;
      acc            <= '0;
      cnt            <= '0;
      dn_req_data    <= '0;
      up_rsp_valid   <= 1'b0;
      up_rsp_data    <= '0;
      up_rsp_mask    <= '0;
      up_rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (up_req_valid) begin
            dn_req_data <= up_req_data;
            issue_pend  <= ALL;
            rsp_mask    <= '0;
            acc         <= NODE_ID;
            cnt         <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE, COLLECT: begin
          cnt      <= cnt_nxt;
          rsp_mask <= mask_nxt;
          acc      <= sum_nxt;
          if (state == ISSUE) issue_pend <= issue_pend & ~dn_req_ready;
          // Completion takes priority over a coincident timeout
          if (done || timed_out) begin
            state          <= RESPOND;
            issue_pend     <= '0;
            up_rsp_valid   <= 1'b1;
            up_rsp_data    <= sum_nxt;
            up_rsp_mask    <= mask_nxt;
            up_rsp_timeout <= !done;
          end else if (state == ISSUE && issue_pend == '0) begin
            state <= COLLECT;
          end
        end
        RESPOND: begin
          if (up_rsp_ready) begin
            up_rsp_valid   <= 1'b0;
            up_rsp_timeout <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hier_bcast_collect_node.sv
// Bench for hier_bcast_collect_node: 16-bit node with short timeout
// and an 8-bit node with NODE_ID for wrap-around.
module tb_hier_bcast_collect_node;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready;
  logic [15:0] req_data;
  logic [4:0]  dn_v, dn_r;
  logic [15:0] dn_d;
  logic [4:0]  rsp_v;
  logic [79:0] rsp_d;
  logic        up_v, up_rdy, up_t, busy;
  logic [15:0] up_d;
  logic [4:0]  up_m;

  logic        b_req_valid, b_req_ready;
  logic [7:0]  b_req_data;
  logic [4:0]  b_dn_v, b_dn_r;
  logic [7:0]  b_dn_d;
  logic [4:0]  b_rsp_v;
  logic [39:0] b_rsp_d;
  logic        b_up_v, b_up_rdy, b_up_t, b_busy;
  logic [7:0]  b_up_d;
  logic [4:0]  b_up_m;

  typedef struct packed {
    logic [15:0] d;
    logic [4:0]  m;
    logic        t;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int total = 0;
  int bad = 0;

  hier_bcast_collect_node #(
    .NUM_CHILD(5), .DATA_W(16), .TIMEOUT(20), .NODE_ID(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .up_req_valid(req_valid), .up_req_ready(req_ready),
    .up_req_data(req_data),
    .dn_req_valid(dn_v), .dn_req_ready(dn_r), .dn_req_data(dn_d),
    .dn_rsp_valid(rsp_v), .dn_rsp_data(rsp_d),
    .up_rsp_valid(up_v), .up_rsp_ready(up_rdy), .up_rsp_data(up_d),
    .up_rsp_mask(up_m), .up_rsp_timeout(up_t), .busy(busy)
  );

  hier_bcast_collect_node #(
    .NUM_CHILD(5), .DATA_W(8), .TIMEOUT(255), .NODE_ID(8'h10)
  ) dut8 (
    .clk(clk), .rst_n(rst_n),
    .up_req_valid(b_req_valid), .up_req_ready(b_req_ready),
    .up_req_data(b_req_data),
    .dn_req_valid(b_dn_v), .dn_req_ready(b_dn_r), .dn_req_data(b_dn_d),
    .dn_rsp_valid(b_rsp_v), .dn_rsp_data(b_rsp_d),
    .up_rsp_valid(b_up_v), .up_rsp_ready(b_up_rdy), .up_rsp_data(b_up_d),
    .up_rsp_mask(b_up_m), .up_rsp_timeout(b_up_t), .busy(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    req_valid = 1'b1;
    req_data  = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_up(input int lim, output int n);
    n = 0;
    while (!up_v && n < lim) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if ({req_ready, busy, dn_v, up_v, up_t} !== 9'b1_0_00000_0_0) begin
      bad++;
      $display("FAIL rst_ctrl got rdy=%b busy=%b dnv=%b upv=%b t=%b want 1 0 0 0 0",
               req_ready, busy, dn_v, up_v, up_t);
    end
    total++;
    if ({dn_d, up_d, up_m} !== 37'd0) begin
      bad++;
      $display("FAIL rst_data got dnd=%h upd=%h m=%b want 0",
               dn_d, up_d, up_m);
    end
    total++;
    if ({b_req_ready, b_busy, b_up_v, b_up_d} !== {3'b100, 8'h00}) begin
      bad++;
      $display("FAIL rst_b got rdy=%b busy=%b v=%b d=%h want 1 0 0 00",
               b_req_ready, b_busy, b_up_v, b_up_d);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    q.push_back('{d: 16'h000F, m: 5'h1F, t: 1'b0});
    send(16'h00A5);
    total++;
    if (dn_v !== 5'h1F || dn_d !== 16'h00A5) begin
      bad++;
      $display("FAIL nom_issue got dnv=%b dnd=%h want 11111 00a5", dn_v, dn_d);
    end
    step();
    for (int i = 0; i < 5; i++) rsp_d[i*16 +: 16] = 16'(i + 1);
    rsp_v = 5'h1F;
    total++;
    if (up_v !== 1'b0) begin
      bad++;
      $display("FAIL nom_early got up_v=%b want 0", up_v);
    end
    step();
    rsp_v = 5'h00;
    total++;
    if (up_v !== 1'b1) begin
      bad++;
      $display("FAIL nom_latency got up_v=%b want 1 at T3", up_v);
    end
    e = q.pop_front();
    total++;
    if ({up_d, up_m, up_t} !== e) begin
      bad++;
      $display("FAIL nom_rsp got d=%h m=%b t=%b want d=%h m=%b t=%b",
               up_d, up_m, up_t, e.d, e.m, e.t);
    end
    up_rdy = 1'b1;
    step();
    up_rdy = 1'b0;
    total++;
    if (up_v !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL nom_idle got v=%b rdy=%b busy=%b want 0 1 0",
               up_v, req_ready, busy);
    end
  endtask

  task automatic test_staggered();
    logic [4:0] pend;
    logic [4:0] rnext;
    int c;
    int errs;
    q.push_back('{d: 16'h003C, m: 5'h1F, t: 1'b0});
    for (int i = 0; i < 5; i++) rsp_d[i*16 +: 16] = 16'(i + 10);
    send(16'h1234);
    pend  = 5'h1F;
    rnext = 5'h00;
    c     = 1;
    errs  = 0;
    while (!up_v && c < 30) begin
      if (dn_v !== pend) begin
        errs++;
        $display("FAIL stag_valid cycle=%0d got dnv=%b want %b", c, dn_v, pend);
      end
      dn_r  = {1'b1, (c >= 4), 2'b11, (c >= 7)};
      rsp_v = rnext;
      rnext = pend & dn_r;
      pend  = pend & ~dn_r;
      step();
      c++;
    end
    rsp_v = 5'h00;
    dn_r  = 5'h1F;
    total++;
    if (errs != 0) bad++;
    total++;
    if (up_v !== 1'b1 || c != 9) begin
      bad++;
      $display("FAIL stag_done got up_v=%b cycle=%0d want 1 cycle 9", up_v, c);
    end
    e = q.pop_front();
    total++;
    if ({up_d, up_m, up_t} !== e) begin
      bad++;
      $display("FAIL stag_rsp got d=%h m=%b t=%b want d=%h m=%b t=%b",
               up_d, up_m, up_t, e.d, e.m, e.t);
    end
    up_rdy = 1'b1;
    step();
    up_rdy = 1'b0;
  endtask

  task automatic test_wrap();
    q.push_back('{d: 16'h0020, m: 5'h1F, t: 1'b0});
    b_req_valid = 1'b1;
    b_req_data  = 8'h5A;
    step();
    b_req_valid = 1'b0;
    step();
    b_rsp_d = {8'h00, 8'h00, 8'h00, 8'h20, 8'hF0};
    b_rsp_v = 5'h1F;
    step();
    b_rsp_v = 5'h00;
    e = q.pop_front();
    total++;
    if ({b_up_v, 8'h00, b_up_d, b_up_m, b_up_t} !== {1'b1, e}) begin
      bad++;
      $display("FAIL wrap_rsp got v=%b d=%h m=%b t=%b want 1 d=%h m=%b t=%b",
               b_up_v, b_up_d, b_up_m, b_up_t, e.d, e.m, e.t);
    end
    b_up_rdy = 1'b1;
    step();
    b_up_rdy = 1'b0;
  endtask

  task automatic test_timeout();
    int c;
    q.push_back('{d: 16'h000C, m: 5'b11011, t: 1'b1});
    for (int i = 0; i < 5; i++) rsp_d[i*16 +: 16] = 16'(i + 1);
    send(16'h0777);
    step();
    rsp_v = 5'b11011;
    step();
    rsp_v = 5'h00;
    c = 3;
    while (!up_v && c < 40) begin
      step();
      c++;
    end
    total++;
    if (up_v !== 1'b1 || c != 21) begin
      bad++;
      $display("FAIL tmo_cycle got up_v=%b cycle=%0d want 1 cycle 21", up_v, c);
    end
    e = q.pop_front();
    total++;
    if ({up_d, up_m, up_t} !== e || dn_v !== 5'h00) begin
      bad++;
      $display("FAIL tmo_rsp got d=%h m=%b t=%b dnv=%b want d=%h m=%b t=%b dnv=0",
               up_d, up_m, up_t, dn_v, e.d, e.m, e.t);
    end
    up_rdy = 1'b1;
    step();
    up_rdy = 1'b0;
  endtask

  task automatic test_abuse();
    int n;
    q.push_back('{d: 16'h000F, m: 5'h1F, t: 1'b0});
    dn_r = 5'b01111;
    send(16'h0BAD);
    rsp_d[4*16 +: 16] = 16'h0100;
    rsp_v = 5'b10000;
    step();
    dn_r = 5'h1F;
    rsp_d[0 +: 16]  = 16'h0001;
    rsp_d[16 +: 16] = 16'h0002;
    rsp_v = 5'b00011;
    step();
    rsp_d[16 +: 16] = 16'h0200;
    rsp_d[32 +: 16] = 16'h0003;
    rsp_v = 5'b00110;
    step();
    rsp_d[48 +: 16] = 16'h0004;
    rsp_d[64 +: 16] = 16'h0005;
    rsp_v = 5'b11000;
    step();
    rsp_v = 5'h00;
    wait_up(10, n);
    total++;
    if (up_v !== 1'b1 || n != 0) begin
      bad++;
      $display("FAIL abuse_wait got up_v=%b extra=%0d want 1 0", up_v, n);
    end
    e = q.pop_front();
    total++;
    if ({up_d, up_m, up_t} !== e) begin
      bad++;
      $display("FAIL abuse_rsp got d=%h m=%b t=%b want d=%h m=%b t=%b",
               up_d, up_m, up_t, e.d, e.m, e.t);
    end
    up_rdy = 1'b1;
    step();
    up_rdy = 1'b0;
  endtask

  task automatic test_backpressure_reset();
    int n;
    int errs;
    q.push_back('{d: 16'h0023, m: 5'h1F, t: 1'b0});
    for (int i = 0; i < 5; i++) rsp_d[i*16 +: 16] = 16'h0007;
    send(16'h0055);
    step();
    rsp_v = 5'h1F;
    step();
    rsp_v = 5'h00;
    e = q.pop_front();
    errs = 0;
    for (int k = 0; k < 10; k++) begin
      if (up_v !== 1'b1 || {up_d, up_m, up_t} !== e) errs++;
      rsp_v = 5'(k);
      step();
    end
    rsp_v = 5'h00;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL bp_stable unstable=%0d got v=%b d=%h m=%b t=%b want 1 d=%h m=%b t=%b",
               errs, up_v, up_d, up_m, up_t, e.d, e.m, e.t);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({up_v, busy, req_ready, up_t, up_d, up_m, dn_d} !== {4'b0010, 37'd0}) begin
      bad++;
      $display("FAIL bp_reset got v=%b busy=%b rdy=%b t=%b d=%h m=%b dnd=%h want reset",
               up_v, busy, req_ready, up_t, up_d, up_m, dn_d);
    end
    #2;
    rst_n = 1'b1;
    step();
    q.push_back('{d: 16'h000F, m: 5'h1F, t: 1'b0});
    for (int i = 0; i < 5; i++) rsp_d[i*16 +: 16] = 16'(i + 1);
    send(16'h0042);
    step();
    rsp_v = 5'h1F;
    step();
    rsp_v = 5'h00;
    wait_up(10, n);
    e = q.pop_front();
    total++;
    if (up_v !== 1'b1 || n != 0 || {up_d, up_m, up_t} !== e) begin
      bad++;
      $display("FAIL post_reset got v=%b wait=%0d d=%h m=%b t=%b want 1 0 d=%h m=%b t=%b",
               up_v, n, up_d, up_m, up_t, e.d, e.m, e.t);
    end
    up_rdy = 1'b1;
    step();
    up_rdy = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_data    = '0;
    dn_r        = 5'h1F;
    rsp_v       = '0;
    rsp_d       = '0;
    up_rdy      = 1'b0;
    b_req_valid = 1'b0;
    b_req_data  = '0;
    b_dn_r      = 5'h1F;
    b_rsp_v     = '0;
    b_rsp_d     = '0;
    b_up_rdy    = 1'b0;
    test_reset();
    test_nominal();
    test_staggered();
    test_wrap();
    test_timeout();
    test_abuse();
    test_backpressure_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
